rr_mux_arbiter: RTL



---
 rtl/rr_mux_arbiter_if.sv | 27 ++
 rtl/rr_mux_arbiter.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/rr_mux_arbiter_if.sv
// Bus bundle between the four requesters and the round-robin mux arbiter.
// The master side drives requests and mux data; the slave side returns grant, select and data.
interface rr_mux_arbiter_if #(
    parameter int W = 1
);
    logic [3:0]   req;
    logic [W-1:0] i0;
    logic [W-1:0] i1;
    logic [W-1:0] i2;
    logic [W-1:0] i3;
    logic [3:0]   gnt;
    logic         s0;
    logic         s1;
    logic [W-1:0] y;
    logic         y_valid;
    logic         busy;

    modport master (
        output req, i0, i1, i2, i3,
        input  gnt, s0, s1, y, y_valid, busy
    );

    modport slave (
        input  req, i0, i1, i2, i3,
        output gnt, s0, s1, y, y_valid, busy
    );
endinterface

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter for a shared 4-to-1 mux: grants one requester at a time for at most
// MAX_HOLD cycles, drives the mux select from the grant and registers the selected input onto y.
module rr_mux_arbiter #(
    parameter int W        = 1,
    parameter int MAX_HOLD = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    rr_mux_arbiter_if.slave bus
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    typedef struct packed {
        logic       found;
        logic [1:0] idx;
    } pick_t;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t       r_state;
    logic [1:0]   r_sel;
    logic [1:0]   r_ptr;
    logic [7:0]   r_hold_cnt;
    logic [3:0]   r_gnt;
    logic [W-1:0] r_y;
    logic         r_y_valid;

    state_t       w_state_nxt;
    logic [1:0]   w_sel_nxt;
    logic [1:0]   w_ptr_nxt;
    logic [7:0]   w_hold_nxt;
    logic [3:0]   w_gnt_nxt;
    logic         w_release;
    pick_t        w_pick;
    logic [W-1:0] w_mux;

    // First asserted request at or after 'start', wrapping mod 4. Scanning from the far end
    // lets the closest candidate overwrite any later one.
    function automatic pick_t rr_pick(input logic [3:0] reqs, input logic [1:0] start);
        pick_t      p;
        logic [1:0] k;
        p = '0;
        for (int n = 3; n >= 0; n--) begin
            k = start + 2'(n);
            if (reqs[k]) begin
                p.found = 1'b1;
                p.idx   = k;
            end
        end
        return p;
    endfunction

    // NOTE: every combinational output gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_ptr_nxt   = r_ptr;
        w_hold_nxt  = r_hold_cnt;
        w_gnt_nxt   = r_gnt;
        w_release   = 1'b0;
        w_pick      = '0;
        case (r_state)
            ST_IDLE: begin
                w_pick = rr_pick(bus.req, r_ptr);
                if (w_pick.found) begin
                    w_state_nxt = ST_GRANT;
                    w_sel_nxt   = w_pick.idx;
                    w_gnt_nxt   = 4'b0001 << w_pick.idx;
                    w_hold_nxt  = 8'd0;
                end
            end
            ST_GRANT: begin
                w_hold_nxt = r_hold_cnt + 8'd1;
                w_release  = !bus.req[r_sel] || (r_hold_cnt == HOLD_LAST);
                if (w_release) begin
                    // The outgoing requester sits out this re-arbitration even if still requesting.
                    w_ptr_nxt = r_sel + 2'd1;
                    w_pick    = rr_pick(bus.req & ~(4'b0001 << r_sel), r_sel + 2'd1);
                    w_hold_nxt = 8'd0;
                    if (w_pick.found) begin
                        w_sel_nxt = w_pick.idx;
                        w_gnt_nxt = 4'b0001 << w_pick.idx;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_gnt_nxt   = 4'b0000;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_mux = '0;
        case (r_sel)
            2'd0: w_mux = bus.i0;
            2'd1: w_mux = bus.i1;
            2'd2: w_mux = bus.i2;
            2'd3: w_mux = bus.i3;
            default: w_mux = '0;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_sel      <= 2'd0;
            r_ptr      <= 2'd0;
            r_hold_cnt <= 8'd0;
            r_gnt      <= 4'b0000;
        end else begin
            r_state    <= w_state_nxt;
            r_sel      <= w_sel_nxt;
            r_ptr      <= w_ptr_nxt;
            r_hold_cnt <= w_hold_nxt;
            r_gnt      <= w_gnt_nxt;
        end
    end

    // Data stage follows the registered select, so y trails the grant by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y       <= '0;
            r_y_valid <= 1'b0;
        end else if (r_state == ST_GRANT) begin
            r_y       <= w_mux;
            r_y_valid <= 1'b1;
        end else begin
            r_y       <= '0;
            r_y_valid <= 1'b0;
        end
    end

    assign bus.gnt     = r_gnt;
    assign bus.s0      = r_sel[0];
    assign bus.s1      = r_sel[1];
    assign bus.y       = r_y;
    assign bus.y_valid = r_y_valid;
    assign bus.busy    = (r_state == ST_GRANT);

endmodule
